// File: rtl/id_issue_ctrl.sv
// Scoreboard issue controller for ID: holds an instruction while any source or destination GPR has a pending long-latency write.
// Outputs are combinational from inputs and scoreboard state; the stall statistics counter is registered.
module id_issue_ctrl #(
  parameter int CNT_W   = 3,
  parameter int MAX_LAT = 4,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic              id_readEnable1_i,
  input  logic [4:0]        id_readAddr1_i,
  input  logic              id_readEnable2_i,
  input  logic [4:0]        id_readAddr2_i,
  input  logic              id_writeEnable_i,
  input  logic [4:0]        id_writeAddr_i,
  input  logic [CNT_W-1:0]  id_lat_i,
  input  logic              ex_stallreq_i,
  input  logic              flush_i,
  output logic [5:0]        stall_o,
  output logic              issue_o,
  output logic [31:0]       busy_o,
  output logic [STAT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);

  logic [CNT_W-1:0]  cnt [32];
  logic [31:0]       busy;
  logic [STAT_W-1:0] stall_cnt;
  logic              raw1, raw2, waw, hazard, hz_stall;
  logic [CNT_W-1:0]  lat_eff;

  always_comb begin
    for (int r = 0; r < 32; r++) busy[r] = (cnt[r] != '0);
  end

  assign raw1    = id_readEnable1_i & (id_readAddr1_i != 5'd0) & busy[id_readAddr1_i];
  assign raw2    = id_readEnable2_i & (id_readAddr2_i != 5'd0) & busy[id_readAddr2_i];
  assign waw     = id_writeEnable_i & (id_writeAddr_i != 5'd0) & busy[id_writeAddr_i];
  assign hazard  = id_valid_i & (raw1 | raw2 | waw);
  assign lat_eff = (id_lat_i > MAX_LAT_C) ? MAX_LAT_C : id_lat_i;

  // Flush beats EX stall beats local hazard; everything is forced quiet in reset.
  always_comb begin
    stall_o  = 6'b000000;
    issue_o  = 1'b0;
    hz_stall = 1'b0;
    if (rst) begin
      stall_o = 6'b000000;
    end else if (flush_i) begin
      stall_o = 6'b000000;
    end else if (ex_stallreq_i) begin
      stall_o = 6'b001111;
    end else if (hazard) begin
      stall_o  = 6'b000111;
      hz_stall = 1'b1;
    end else begin
      issue_o = id_valid_i;
    end
  end

  // A new load on a register overrides its decrement; in-flight counts keep draining during any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (issue_o && id_writeEnable_i && (id_writeAddr_i == r[4:0]) && (id_lat_i != '0))
          cnt[r] <= lat_eff;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (hz_stall && (stall_cnt != {STAT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign busy_o      = rst ? 32'd0 : busy;
  assign stall_cnt_o = rst ? '0 : stall_cnt;

endmodule
